tft_spi_tx: RTL and testbench



---
 rtl/tft_spi_tx.sv | 193 +++++++++++++++++++
 tb/tb_tft_spi_tx.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_spi_tx.sv
// Avalon-MM slave that queues {dc, byte} entries and shifts them out
// to an SPI TFT panel in mode 0, holding tft_dc for the whole byte.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   address, chipselect,     Avalon-MM slave bus:
//   write_n, read_n,           addr 0 TXDATA (push), addr 1 STATUS,
//   writedata, readdata        readdata is combinational (zero latency)
//   dc_in                    D/C level from the upstream PIO, tagged per push
//   tft_cs_n, tft_sck,       panel SPI lines (SCK idles low, MSB first)
//   tft_mosi, tft_dc
module tft_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        dc_in,
  output logic        tft_cs_n,
  output logic        tft_sck,
  output logic        tft_mosi,
  output logic        tft_dc
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LVL_W = FIFO_AW + 1;
  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t r_state, w_state_nx;

  logic [8:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_ovf;

  logic [7:0] r_div, w_div_nx;
  logic [2:0] r_bit, w_bit_nx;
  logic       r_last, w_last_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_dc, w_dc_nx;
  logic       w_pop;

  logic w_wr, w_push_req, w_push, w_full;
  logic w_empty, w_clr, w_busy;
  logic [8:0] w_head;
  logic w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_push_req = w_wr & (address == 2'd0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  // room is judged on the pre-pop level only
  assign w_push     = w_push_req & ~w_full;
  assign w_clr      = w_wr & (address == 2'd1) & writedata[2];
  assign w_head     = r_mem[r_rptr];
  assign w_busy     = ~w_empty | (r_state != S_IDLE);
  assign w_unused   = ^{read_n, writedata[31:8]};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {dc_in, writedata[7:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop)      r_level <= r_level + 1'b1;
      else if (~w_push & w_pop) r_level <= r_level - 1'b1;
      // a new overflow wins over a clear in the same cycle
      if (w_push_req & w_full) r_ovf <= 1'b1;
      else if (w_clr)          r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_last  <= 1'b0;
      r_shift <= '0;
      r_dc    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_bit   <= w_bit_nx;
      r_last  <= w_last_nx;
      r_shift <= w_shift_nx;
      r_dc    <= w_dc_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_bit_nx   = r_bit;
    w_last_nx  = r_last;
    w_shift_nx = r_shift;
    w_dc_nx    = r_dc;
    w_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_head[7:0];
          w_dc_nx    = w_head[8];
          w_bit_nx   = 3'd7;
          w_last_nx  = 1'b0;
          w_div_nx   = DIV_LD;
          w_state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_div == 8'd0) begin
          w_div_nx   = DIV_LD;
          w_state_nx = S_HIGH;
        end else begin
          w_div_nx = r_div - 8'd1;
        end
      end
      S_HIGH: begin
        if (r_div == 8'd0) begin
          w_div_nx   = DIV_LD;
          w_state_nx = S_LOW;
          // r_last marks the LOW phase that follows bit 0
          if (r_bit != 3'd0) begin
            w_bit_nx   = r_bit - 3'd1;
            w_shift_nx = {r_shift[6:0], 1'b0};
          end else begin
            w_last_nx = 1'b1;
          end
        end else begin
          w_div_nx = r_div - 8'd1;
        end
      end
      S_LOW: begin
        if (r_div == 8'd0) begin
          if (!r_last) begin
            w_div_nx   = DIV_LD;
            w_state_nx = S_HIGH;
          end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_head[7:0];
            w_dc_nx    = w_head[8];
            w_bit_nx   = 3'd7;
            w_last_nx  = 1'b0;
            w_div_nx   = DIV_LD;
            w_state_nx = S_SETUP;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_div_nx = r_div - 8'd1;
        end
      end
    endcase
  end

  assign tft_cs_n = (r_state == S_IDLE);
  assign tft_sck  = (r_state == S_HIGH);
  assign tft_mosi = r_shift[7];
  assign tft_dc   = r_dc;

  always_comb begin
    readdata = '0;
    if (address == 2'd1) begin
      readdata[0] = w_busy;
      readdata[1] = w_full;
      readdata[2] = r_ovf;
      readdata[8 +: LVL_W] = r_level;
    end
  end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Self-checking bench for tft_spi_tx: SPI stream, FIFO, STATUS,
// overflow, reset abort, and CLK_DIV=1 timing.
module tb_tft_spi_tx;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] address;
  logic chipselect, write_n, read_n;
  logic [31:0] writedata;
  logic dc_in;
  logic [31:0] a_rd, b_rd;
  logic a_cs, a_sck, a_mosi, a_dc;
  logic b_cs, b_sck, b_mosi, b_dc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tft_spi_tx #(.CLK_DIV(2), .FIFO_AW(4)) u_a (
    .clk(clk), .reset(rst), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .read_n(read_n), .writedata(writedata),
    .readdata(a_rd), .dc_in(dc_in),
    .tft_cs_n(a_cs), .tft_sck(a_sck),
    .tft_mosi(a_mosi), .tft_dc(a_dc)
  );

  tft_spi_tx #(.CLK_DIV(1), .FIFO_AW(4)) u_b (
    .clk(clk), .reset(rst), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .read_n(read_n), .writedata(writedata),
    .readdata(b_rd), .dc_in(dc_in),
    .tft_cs_n(b_cs), .tft_sck(b_sck),
    .tft_mosi(b_mosi), .tft_dc(b_dc)
  );

  // panel-side monitors: {dc,mosi} at each SCK rise, cs_n low run lengths
  logic [1:0] a_obs[$];
  logic [1:0] b_obs[$];
  int a_runs[$];
  int b_runs[$];
  int b_rise[$];
  int a_run = 0;
  int b_run = 0;
  logic a_psck = 1'b0;
  logic b_psck = 1'b0;

  always @(negedge clk) begin
    if (a_sck && !a_psck) a_obs.push_back({a_dc, a_mosi});
    a_psck = a_sck;
    if (!a_cs) a_run = a_run + 1;
    else if (a_run > 0) begin
      a_runs.push_back(a_run);
      a_run = 0;
    end
    if (b_sck && !b_psck) begin
      b_obs.push_back({b_dc, b_mosi});
      b_rise.push_back(cyc);
    end
    b_psck = b_sck;
    if (!b_cs) b_run = b_run + 1;
    else if (b_run > 0) begin
      b_runs.push_back(b_run);
      b_run = 0;
    end
  end

  // {dc_inconsistent, dc, byte} of observed byte i
  function automatic logic [9:0] obs_byte(input logic [1:0] q[$], input int i);
    logic [7:0] b;
    logic d0, bad;
    d0 = q[8*i][1];
    bad = 1'b0;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      b[7-k] = q[8*i+k][0];
      if (q[8*i+k][1] !== d0) bad = 1'b1;
    end
    return {bad, d0, b};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic dc);
    address = a;
    writedata = d;
    dc_in = dc;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] va, output logic [31:0] vb);
    address = a;
    chipselect = 1'b1;
    read_n = 1'b0;
    #1;
    va = a_rd;
    vb = b_rd;
    chipselect = 1'b0;
    read_n = 1'b1;
  endtask

  task automatic wait_runs(input bit sel_b, input int n, input int bound, output bit ok);
    int k;
    k = 0;
    while (((sel_b ? b_runs.size() : a_runs.size()) < n) && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    ok = (sel_b ? b_runs.size() : a_runs.size()) >= n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_obs.delete();
    a_runs.delete();
    b_obs.delete();
    b_runs.delete();
    b_rise.delete();
  endtask

  task automatic test_reset();
    logic [31:0] va, vb;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_cs, a_sck, a_mosi, a_dc} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_pins: got %b want 1000", {a_cs, a_sck, a_mosi, a_dc});
    end
    rst = 1'b0;
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0) begin
      failures++;
      $display("FAIL reset_status: got %h want 0", va);
    end
    wr(2'd2, 32'hFFFF_FFFF, 1'b1);
    wr(2'd3, 32'hFFFF_FFFF, 1'b1);
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0) begin
      failures++;
      $display("FAIL ignored_writes: got %h want 0", va);
    end
    rd(2'd0, va, vb);
    checks++;
    if (va !== 32'h0) begin
      failures++;
      $display("FAIL read_txdata: got %h want 0", va);
    end
    rd(2'd3, va, vb);
    checks++;
    if (va !== 32'h0) begin
      failures++;
      $display("FAIL read_addr3: got %h want 0", va);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] va, vb;
    bit ok;
    logic [9:0] got;
    do_reset();
    wr(2'd0, 32'h0000_00A5, 1'b0);
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0000_0101 || a_cs !== 1'b1) begin
      failures++;
      $display("FAIL single_after_wr: got status %h cs %b want 00000101 cs 1", va, a_cs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_cs !== 1'b0) begin
      failures++;
      $display("FAIL single_cs_fall: got %b want 0", a_cs);
    end
    wait_runs(1'b0, 1, 200, ok);
    checks++;
    if (!ok || a_obs.size() != 8) begin
      failures++;
      $display("FAIL single_edges: got %0d want 8", a_obs.size());
    end else begin
      got = obs_byte(a_obs, 0);
      checks++;
      if (got !== {2'b00, 8'hA5}) begin
        failures++;
        $display("FAIL single_byte: got %h want %h", got, {2'b00, 8'hA5});
      end
      checks++;
      if (a_runs[0] != 34) begin
        failures++;
        $display("FAIL single_cs_low: got %0d want 34", a_runs[0]);
      end
    end
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0) begin
      failures++;
      $display("FAIL single_busy: got %h want 0", va);
    end
  endtask

  task automatic test_mixed_stream();
    logic [8:0] exp[3];
    bit ok;
    logic [9:0] got;
    exp[0] = {1'b0, 8'h2A};
    exp[1] = {1'b1, 8'h00};
    exp[2] = {1'b1, 8'hEF};
    do_reset();
    for (int i = 0; i < 3; i++) wr(2'd0, {24'h0, exp[i][7:0]}, exp[i][8]);
    wait_runs(1'b0, 1, 400, ok);
    checks++;
    if (!ok || a_obs.size() != 24 || a_runs[0] != 102) begin
      failures++;
      $display("FAIL mixed_shape: got edges %0d run %0d want 24 102",
               a_obs.size(), ok ? a_runs[0] : -1);
    end else begin
      for (int i = 0; i < 3; i++) begin
        got = obs_byte(a_obs, i);
        checks++;
        if (got !== {1'b0, exp[i]}) begin
          failures++;
          $display("FAIL mixed_byte%0d: got %h want %h", i, got, {1'b0, exp[i]});
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va, vb;
    logic [8:0] exp[$];
    int w1;
    bit ok;
    logic [9:0] got;
    do_reset();
    w1 = cyc + 1;
    for (int i = 0; i < 18; i++) begin
      wr(2'd0, 32'h10 + i, 1'(i & 1));
      if (i < 17) exp.push_back({1'(i & 1), 8'(8'h10 + i)});
    end
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0000_1007) begin
      failures++;
      $display("FAIL ovf_status: got %h want 00001007", va);
    end
    wr(2'd1, 32'h4, 1'b0);
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0000_1003) begin
      failures++;
      $display("FAIL ovf_clear: got %h want 00001003", va);
    end
    // second pop lands 1 + 34 edges after the first write
    while (cyc + 1 < w1 + 35) begin
      @(posedge clk);
      #1;
    end
    wr(2'd0, 32'h77, 1'b1);
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0000_0F05) begin
      failures++;
      $display("FAIL push_pop_full: got %h want 00000F05", va);
    end
    wait_runs(1'b0, 1, 17 * 34 + 100, ok);
    checks++;
    if (!ok || a_obs.size() != 8 * 17 || a_runs[0] != 17 * 34) begin
      failures++;
      $display("FAIL ovf_stream: got edges %0d want %0d", a_obs.size(), 8 * 17);
    end else begin
      for (int i = 0; i < 17; i++) begin
        got = obs_byte(a_obs, i);
        checks++;
        if (got !== {1'b0, exp[i]}) begin
          failures++;
          $display("FAIL ovf_byte%0d: got %h want %h", i, got, {1'b0, exp[i]});
        end
      end
    end
  endtask

  task automatic test_reset_midbyte();
    logic [31:0] va, vb;
    int k, nr;
    do_reset();
    for (int i = 0; i < 3; i++) wr(2'd0, 32'hFF, 1'b1);
    k = 0;
    while (a_obs.size() < 5 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (a_obs.size() < 5 || {a_cs, a_mosi, a_dc} !== 3'b011) begin
      failures++;
      $display("FAIL mid_reached: got edges %0d pins %b want 5 011",
               a_obs.size(), {a_cs, a_mosi, a_dc});
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_cs, a_sck, a_mosi, a_dc} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_async: got %b want 1000", {a_cs, a_sck, a_mosi, a_dc});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(2'd1, va, vb);
    checks++;
    if (va !== 32'h0) begin
      failures++;
      $display("FAIL mid_status: got %h want 0", va);
    end
    nr = a_obs.size();
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (a_obs.size() != nr || a_cs !== 1'b1) begin
      failures++;
      $display("FAIL mid_quiet: got edges %0d cs %b want %0d 1", a_obs.size(), a_cs, nr);
    end
  endtask

  task automatic test_div1();
    logic [31:0] va, vb;
    bit ok;
    int bad;
    do_reset();
    wr(2'd0, 32'hFF, 1'b1);
    wait_runs(1'b1, 1, 100, ok);
    checks++;
    if (!ok || b_obs.size() != 8 || b_runs[0] != 17) begin
      failures++;
      $display("FAIL div1_shape: got edges %0d run %0d want 8 17",
               b_obs.size(), ok ? b_runs[0] : -1);
    end else begin
      checks++;
      if (obs_byte(b_obs, 0) !== {2'b01, 8'hFF}) begin
        failures++;
        $display("FAIL div1_byte: got %h want 1ff", obs_byte(b_obs, 0));
      end
      bad = 0;
      for (int i = 1; i < 8; i++) if (b_rise[i] - b_rise[i-1] != 2) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL div1_period: got %0d bad periods want 0", bad);
      end
    end
    rd(2'd1, va, vb);
    checks++;
    if (vb !== 32'h0) begin
      failures++;
      $display("FAIL div1_busy: got %h want 0", vb);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp[$];
    logic [31:0] va, vb;
    int n;
    bit ok;
    logic [9:0] got;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      exp.delete();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        exp.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
        wr(2'd0, {24'h0, exp[i][7:0]}, exp[i][8]);
      end
      wait_runs(1'b0, 1, n * 34 + 100, ok);
      checks++;
      if (!ok || a_obs.size() != 8 * n || a_runs[0] != 34 * n) begin
        failures++;
        $display("FAIL rand%0d_shape: got edges %0d want %0d", r, a_obs.size(), 8 * n);
      end else begin
        for (int i = 0; i < n; i++) begin
          got = obs_byte(a_obs, i);
          checks++;
          if (got !== {1'b0, exp[i]}) begin
            failures++;
            $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, got, {1'b0, exp[i]});
          end
        end
      end
      rd(2'd1, va, vb);
      checks++;
      if (va !== 32'h0) begin
        failures++;
        $display("FAIL rand%0d_idle: got %h want 0", r, va);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    read_n = 1'b1;
    writedata = '0;
    dc_in = 1'b0;
    test_reset();
    test_single_byte();
    test_mixed_stream();
    test_overflow();
    test_reset_midbyte();
    test_div1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
